// File: rtl/garo_move_if.sv
// Signal bundle between the battle control/HP logic and the move unit.
interface garo_move_if;
    logic       stop;
    logic       actr;
    logic [1:0] p_move;
    logic [1:0] ai_rnd;
    logic [3:0] accu_rnd;
    logic [1:0] move;
    logic [3:0] dmg;
    logic [3:0] accu;
    logic       hit;

    modport master (
        output stop, actr, p_move,
        input  ai_rnd, accu_rnd, move, dmg, accu, hit
    );

    modport slave (
        input  stop, actr, p_move,
        output ai_rnd, accu_rnd, move, dmg, accu, hit
    );
endinterface

// File: rtl/garo_move_unit.sv
// Stoppable Galois LFSR supplying AI move and accuracy roll, plus the trainer mux
// and move table that turn the chosen move into damage, accuracy and a hit flag.
module garo_move_unit #(
    parameter logic [15:0] SEED = 16'hACE1,
    parameter logic [15:0] POLY = 16'hB400,
    parameter logic [3:0]  DMG0 = 4'd3,
    parameter logic [3:0]  DMG1 = 4'd5,
    parameter logic [3:0]  DMG2 = 4'd8,
    parameter logic [3:0]  DMG3 = 4'd12,
    parameter logic [3:0]  ACC0 = 4'd15,
    parameter logic [3:0]  ACC1 = 4'd12,
    parameter logic [3:0]  ACC2 = 4'd8,
    parameter logic [3:0]  ACC3 = 4'd4
) (
    input  logic         clk,
    input  logic         reset,
    garo_move_if.slave   bus
);

    // An all-zero seed would lock the LFSR, so it is swapped for the default.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;

    logic [15:0] lfsr_q, lfsr_d;
    logic [1:0]  move_q, move_d;

    function automatic logic [3:0] dmg_of(input logic [1:0] m);
        case (m)
            2'd0:    dmg_of = DMG0;
            2'd1:    dmg_of = DMG1;
            2'd2:    dmg_of = DMG2;
            default: dmg_of = DMG3;
        endcase
    endfunction

    function automatic logic [3:0] acc_of(input logic [1:0] m);
        case (m)
            2'd0:    acc_of = ACC0;
            2'd1:    acc_of = ACC1;
            2'd2:    acc_of = ACC2;
            default: acc_of = ACC3;
        endcase
    endfunction

    always_comb begin
        lfsr_d = lfsr_q;
        if (!bus.stop) begin
            lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ POLY) : (lfsr_q >> 1);
        end
        // The AI choice is taken from the LFSR value present before this edge.
        move_d = bus.actr ? lfsr_q[1:0] : bus.p_move;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= SEED_EFF;
            move_q <= 2'b00;
        end else begin
            lfsr_q <= lfsr_d;
            move_q <= move_d;
        end
    end

    assign bus.ai_rnd   = lfsr_q[1:0];
    assign bus.accu_rnd = lfsr_q[5:2];
    assign bus.move     = move_q;
    assign bus.dmg      = dmg_of(move_q);
    assign bus.accu     = acc_of(move_q);
    assign bus.hit      = (acc_of(move_q) >= lfsr_q[5:2]);

endmodule

// File: tb/tb_garo_move_unit.sv
// Directed/random bench for garo_move_unit with a reference LFSR model and a
// queue of expected registered moves.
module tb_garo_move_unit;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [15:0] POLY = 16'hB400;

    logic clk = 1'b0;
    logic reset;
    garo_move_if mif ();

    garo_move_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [15:0] m_lfsr;
    logic [1:0]  sb[$];
    logic [3:0]  dmg_t [4] = '{4'd3, 4'd5, 4'd8, 4'd12};
    logic [3:0]  acc_t [4] = '{4'd15, 4'd12, 4'd8, 4'd4};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] step_lfsr(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ POLY) : (v >> 1);
    endfunction

    // Queue the move expected after this edge, advance one clock, update the model.
    task automatic tick();
        logic [15:0] nl;
        nl = mif.stop ? m_lfsr : step_lfsr(m_lfsr);
        sb.push_back(mif.actr ? m_lfsr[1:0] : mif.p_move);
        @(posedge clk);
        #1;
        m_lfsr = nl;
    endtask

    task automatic check_all(input string tag);
        logic [1:0] em;
        logic [3:0] ea;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 16'd1, 16'd0);
            return;
        end
        em = sb.pop_front();
        ea = acc_t[em];
        chk({tag, "_lfsr"},     dut.lfsr_q,        m_lfsr);
        chk({tag, "_move"},     {14'd0, mif.move}, {14'd0, em});
        chk({tag, "_dmg"},      {12'd0, mif.dmg},  {12'd0, dmg_t[em]});
        chk({tag, "_accu"},     {12'd0, mif.accu}, {12'd0, ea});
        chk({tag, "_ai_rnd"},   {14'd0, mif.ai_rnd},   {14'd0, m_lfsr[1:0]});
        chk({tag, "_accu_rnd"}, {12'd0, mif.accu_rnd}, {12'd0, m_lfsr[5:2]});
        chk({tag, "_hit"},      {15'd0, mif.hit},  {15'd0, (ea >= m_lfsr[5:2])});
    endtask

    initial begin
        int n;
        bit zero_seen;
        reset = 1'b1;
        mif.stop = 1'b0;
        mif.actr = 1'b0;
        mif.p_move = 2'd0;
        m_lfsr = SEED;
        #12;
        // Reset state
        chk("rst_lfsr",     dut.lfsr_q, 16'hACE1);
        chk("rst_move",     {14'd0, mif.move},     16'd0);
        chk("rst_dmg",      {12'd0, mif.dmg},      16'd3);
        chk("rst_accu",     {12'd0, mif.accu},     16'd15);
        chk("rst_ai_rnd",   {14'd0, mif.ai_rnd},   16'd1);
        chk("rst_accu_rnd", {12'd0, mif.accu_rnd}, 16'd8);
        chk("rst_hit",      {15'd0, mif.hit},      16'd1);
        @(negedge clk);
        reset = 1'b0;

        // First two steps
        tick(); check_all("step1");
        chk("step1_const", dut.lfsr_q, 16'hE270);
        chk("step1_ai",    {14'd0, mif.ai_rnd},   16'd0);
        chk("step1_acc",   {12'd0, mif.accu_rnd}, 16'd12);
        tick(); check_all("step2");
        chk("step2_const", dut.lfsr_q, 16'h7138);

        // Freeze for 10 clocks, then resume
        mif.stop = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(); check_all("stop");
        end
        chk("stop_held", dut.lfsr_q, 16'h7138);
        mif.stop = 1'b0;
        tick(); check_all("resume");
        chk("resume_const", dut.lfsr_q, 16'h389C);

        // Player moves through the mux
        mif.p_move = 2'd2;
        tick(); check_all("pm2");
        chk("pm2_dmg",  {12'd0, mif.dmg},  16'd8);
        chk("pm2_accu", {12'd0, mif.accu}, 16'd8);
        mif.p_move = 2'd3;
        tick(); check_all("pm3");
        chk("pm3_dmg",  {12'd0, mif.dmg},  16'd12);
        chk("pm3_accu", {12'd0, mif.accu}, 16'd4);

        // AI moves with random stop/p_move
        mif.actr = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            mif.stop   = ($urandom_range(0, 3) == 0);
            mif.p_move = 2'($urandom_range(0, 3));
            tick(); check_all("rnd");
        end
        mif.stop = 1'b0;

        // Asynchronous reset mid-run, between clock edges
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("async_lfsr", dut.lfsr_q, SEED);
        chk("async_move", {14'd0, mif.move}, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        m_lfsr = SEED;
        tick(); check_all("restart1");
        chk("restart1_const", dut.lfsr_q, 16'hE270);
        tick(); check_all("restart2");

        // Full period from SEED
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        zero_seen = 1'b0;
        while (n < 70000) begin
            @(posedge clk);
            #1;
            n++;
            if (dut.lfsr_q == 16'h0000) zero_seen = 1'b1;
            if (dut.lfsr_q == SEED) break;
        end
        chk("period_len",  16'(n), 16'(65535));
        chk("period_zero", {15'd0, zero_seen}, 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
